regfile_access_ctrl: RTL and testbench
======================================

// Module: regfile_access_ctrl
// PURPOSE
//  Shares the single read/write port of the 8x16 REGFILE among N_REQ requesters (decode/read, writeback, debug).
//  Round-robin arbitration, valid/ready request handshake, registered drive of data_in/writenum/write/readnum.
//  Read data is captured from REGFILE data_out and returned with a one-cycle rsp_valid pulse.
//  Sits between datapath requesters and REGFILE; owns the REGFILE control signals outright.
// PARAMETERS
//  DATA_W  16  register width (matches REGFILE)
//  ADDR_W  3   register index width (8 registers)
//  N_REQ   2   number of requesters, legal 2..4
// PORTS
//  clk          in   1              single clock, rising edge
//  rst_n        in   1              asynchronous, active-low reset
//  req_valid    in   N_REQ          per-requester request valid
//  req_we       in   N_REQ          1=write, 0=read
//  req_addr     in   N_REQ*ADDR_W   register index, slice i = [i*ADDR_W +: ADDR_W]
//  req_wdata    in   N_REQ*DATA_W   write data, slice i likewise
//  req_ready    out  N_REQ          one-hot grant; transfer when valid&ready
//  rsp_valid    out  N_REQ          one-cycle pulse to the requester whose read completed
//  rsp_rdata    out  DATA_W         read data, valid while any rsp_valid bit is high
//  rf_data_in   out  DATA_W         to REGFILE data_in
//  rf_writenum  out  ADDR_W         to REGFILE writenum
//  rf_write     out  1              to REGFILE write
//  rf_readnum   out  ADDR_W         to REGFILE readnum
//  rf_data_out  in   DATA_W         from REGFILE data_out (combinational read)
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; all outputs 0; last_grant=N_REQ-1 so requester 0 wins first.
//  - FSM states: IDLE, WRITE, READ, RESP.
//  - IDLE: req_ready is one-hot to the first valid requester after last_grant (wrapping); 0 if none valid.
//    req_ready depends only on req_valid and state (no valid->ready loop through other inputs).
//  - Accept in cycle T: last_grant<=winner. Write -> WRITE; read -> READ.
//  - WRITE (T+1): rf_write=1, rf_writenum/rf_data_in = captured addr/data; REGFILE commits at end of T+1; -> IDLE.
//  - READ (T+1): rf_readnum=captured addr; rsp_rdata<=rf_data_out at end of T+1; -> RESP.
//  - RESP (T+2): rsp_valid[owner]=1 for exactly one cycle; -> IDLE.
//  - Latency: write 2 cycles to commit, read 2 cycles to rsp_valid; one op in flight; req_ready=0 outside IDLE.
//  - rf_write is 0 in every state except WRITE; rf_writenum/rf_data_in/rf_readnum/rsp_rdata hold last value otherwise.
//  - Read accepted the cycle after a write to the same index returns the new value (write commits first).
//  - Requester dropping req_valid while not granted: no effect; no request is latched before acceptance.
//  - Requester set changing in IDLE: grant recomputed combinationally each cycle; no starvation—every valid
//    requester is granted within N_REQ accepts.
//  - Reset asserted mid-operation: in-flight write suppressed (rf_write falls immediately), pending
//    response dropped, no rsp_valid after reset release.
// CONFIGURATION
//  - Macro RFC_R0_ZERO_EN.
//  - Defined: register 0 hardwired zero—write to index 0 accepted, passes WRITE state with rf_write=0;
//    read of index 0 returns 0 in RESP regardless of rf_data_out. Latency unchanged.
//  - Undefined: index 0 is an ordinary register.
// STRUCTURE
//  - Package regfile_ctrl_pkg: DATA_W/ADDR_W/NREGS constants, FSM state encoding (IDLE/WRITE/READ/RESP).
//  - Sub-module rr_arbiter (N parameter): req vector + last_grant in, one-hot grant + index out; combinational.
//  - Top holds FSM, captured request (we, addr, data, owner) and REGFILE drive registers.
// TESTING (bench instantiates REGFILE + this block)
//  - Req0 write addr=1 data=16'h0002, then read addr=1 -> rf_write high 1 cycle, rsp_valid[0] 2 cycles after
//    read accept, rsp_rdata=16'h0002.
//  - Req0 and req1 both valid, writes to addr 2 (16'h8CFA) and 3 (16'hF080) -> grants 0 then 1; reads return both.
//  - Both held valid for 6 reads -> grants alternate 0,1,0,1,0,1; no rsp_valid on the non-owner.
//  - Write addr=4 16'h020F then immediately read addr=4 -> rsp_rdata=16'h020F.
//  - rst_n low during WRITE for addr=5 16'hA800 -> rf_write drops at once; later read addr=5 returns prior value.
//  - With RFC_R0_ZERO_EN: write addr=0 16'hFFFF -> rf_write stays 0; read addr=0 -> rsp_rdata=16'h0000.
//    Without macro: same read returns 16'hFFFF.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared constants for the REGFILE access controller: register geometry and FSM encoding.
// No logic, so there is no latency.
// No flow control lives here.
// Optional feature RFC_R0_ZERO_EN (used by regfile_access_ctrl) makes register 0 read as zero.
package regfile_ctrl_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 3;
  localparam int RF_NREGS  = 8;

  // FSM encoding. Plain constants keep the encoding visible to older tools and to waveforms.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first set req bit after last_grant, wrapping around.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is actually taken.
// Ports: req[N] in, last_grant[IW] in, grant[N] one-hot out (all zero if no req), grant_idx[IW] out.
module rr_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic          found;
  logic [IW:0]   cand;

  // Scan from last_grant+1 to last_grant+N (mod N). The previous winner is
  // looked at last, which bounds any requester's wait to N accepts.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last_grant} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && req[cand[IW-1:0]]) begin
        found            = 1'b1;
        grant_idx        = cand[IW-1:0];
        grant[cand[IW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Shares the single port of the 8x16 REGFILE among N_REQ requesters with round-robin arbitration.
// Latency: a write commits 2 cycles after accept; a read returns rsp_valid 2 cycles after accept.
// Backpressure: req_ready is low whenever an op is in flight (one op at a time), so there is no queueing.
// Ports: clk, rst_n; req_valid/req_we/req_addr/req_wdata in, req_ready out; rsp_valid/rsp_rdata out;
//        rf_data_in/rf_writenum/rf_write/rf_readnum out to REGFILE, rf_data_out in from REGFILE.
// Config: define RFC_R0_ZERO_EN to hardwire register 0 to zero (writes dropped, reads return 0).
module regfile_access_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int N_REQ  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [DATA_W-1:0]        rf_data_in,
  output logic [ADDR_W-1:0]        rf_writenum,
  output logic                     rf_write,
  output logic [ADDR_W-1:0]        rf_readnum,
  input  logic [DATA_W-1:0]        rf_data_out
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

`ifdef RFC_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic [1:0]        state;
  logic [IW-1:0]     last_grant;   // also identifies the owner of the op in flight
  logic [N_REQ-1:0]  win;
  logic [IW-1:0]     win_idx;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (win),
    .grant_idx  (win_idx)
  );

  // Grant depends only on req_valid and state, never on addr/data/we.
  assign req_ready = (state == ST_IDLE) ? win : '0;
  assign win_addr  = req_addr [int'(win_idx)*ADDR_W +: ADDR_W];
  assign win_data  = req_wdata[int'(win_idx)*DATA_W +: DATA_W];

  // The REGFILE drive registers double as the captured request, so no
  // separate request latch exists and nothing is held before acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_grant  <= IW'(N_REQ - 1);
      rf_write    <= 1'b0;
      rf_writenum <= '0;
      rf_data_in  <= '0;
      rf_readnum  <= '0;
      rsp_rdata   <= '0;
      rsp_valid   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|win) begin
            last_grant <= win_idx;
            if (req_we[win_idx]) begin
              state       <= ST_WRITE;
              // With register 0 hardwired, the op still takes its WRITE cycle but never strobes.
              rf_write    <= !(R0_ZERO && (win_addr == '0));
              rf_writenum <= win_addr;
              rf_data_in  <= win_data;
            end else begin
              state      <= ST_READ;
              rf_readnum <= win_addr;
            end
          end
        end
        ST_WRITE: begin
          rf_write <= 1'b0;
          state    <= ST_IDLE;
        end
        ST_READ: begin
          rsp_rdata <= (R0_ZERO && (rf_readnum == '0)) ? '0 : rf_data_out;
          rsp_valid <= N_REQ'(1) << last_grant;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          rsp_valid <= '0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl with a behavioural 8x16 REGFILE attached.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Checks reset state, arbitration order, write/read latency, the RFC_R0_ZERO_EN option and mid-op reset.
module tb_regfile_access_ctrl;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 2;

`ifdef RFC_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic [NR-1:0]      req_valid, req_we, req_ready, rsp_valid;
  logic [NR*AW-1:0]   req_addr;
  logic [NR*DW-1:0]   req_wdata;
  logic [DW-1:0]      rsp_rdata, rf_data_in, rf_data_out;
  logic [AW-1:0]      rf_writenum, rf_readnum;
  logic               rf_write;

  regfile_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .N_REQ(NR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rf_data_in  (rf_data_in),
    .rf_writenum (rf_writenum),
    .rf_write    (rf_write),
    .rf_readnum  (rf_readnum),
    .rf_data_out (rf_data_out)
  );

  // REGFILE: synchronous write, combinational read, no reset.
  logic [DW-1:0] regs [8];
  always_ff @(posedge clk) if (rf_write) regs[rf_writenum] <= rf_data_in;
  assign rf_data_out = regs[rf_readnum];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait (bounded) for any grant; sampled on the falling edge.
  task automatic wait_grant(input string name, output logic [NR-1:0] g);
    g = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        g = req_ready;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s: no grant within 20 cycles", name);
  endtask

  // One op from requester r alone; caller is 1 unit after a rising edge.
  task automatic run_op(input string tag, input int r, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] exp);
    logic [NR-1:0] g;
    logic exp_we;
    exp_we = we && !(R0Z && a == '0);
    req_valid = '0;
    req_valid[r] = 1'b1;
    req_we[r] = we;
    req_addr[r*AW +: AW] = a;
    req_wdata[r*DW +: DW] = d;
    wait_grant({tag, "_grant"}, g);
    chk({tag, "_grant"}, 32'(g), 32'(1 << r));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);            // cycle T+1
    if (we) begin
      chk({tag, "_wr_strobe"}, 32'(rf_write), 32'(exp_we));
      chk({tag, "_wr_num"}, 32'(rf_writenum), 32'(a));
      chk({tag, "_wr_data"}, 32'(rf_data_in), 32'(d));
    end else begin
      chk({tag, "_rsp_early"}, 32'(rsp_valid), 32'(0));
    end
    @(negedge clk);            // cycle T+2
    if (we) begin
      chk({tag, "_wr_done"}, 32'(rf_write), 32'(0));
    end else begin
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(1 << r));
      chk({tag, "_rsp_data"}, 32'(rsp_rdata), 32'(exp));
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    string         tag;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [NR-1:0] g;

    tbl[0] = '{"w1",  1'b1, 3'd1, 16'h0002, 16'h0000};
    tbl[1] = '{"r1",  1'b0, 3'd1, 16'h0000, 16'h0002};
    tbl[2] = '{"w4",  1'b1, 3'd4, 16'h020F, 16'h0000};
    tbl[3] = '{"r4",  1'b0, 3'd4, 16'h0000, 16'h020F};   // read right after the write
    tbl[4] = '{"w5",  1'b1, 3'd5, 16'h1234, 16'h0000};
    tbl[5] = '{"r5",  1'b0, 3'd5, 16'h0000, 16'h1234};
    tbl[6] = '{"w0",  1'b1, 3'd0, 16'hFFFF, 16'h0000};
    tbl[7] = '{"r0",  1'b0, 3'd0, 16'h0000, R0Z ? 16'h0000 : 16'hFFFF};

    rst_n = 1'b0;
    req_valid = '0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    #22;
    chk("rst_ready", 32'(req_ready), 32'(0));
    chk("rst_rf_write", 32'(rf_write), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rdata", 32'(rsp_rdata), 32'(0));
    chk("rst_writenum", 32'(rf_writenum), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Arbitration out of reset: requester 0 wins first; lone requester 1 is granted.
    req_valid = 2'b10;
    #1 chk("arb_only1", 32'(req_ready), 32'(2'b10));
    req_valid = 2'b11;
    #1 chk("arb_both", 32'(req_ready), 32'(2'b01));
    req_valid = 2'b00;
    #1 chk("arb_none", 32'(req_ready), 32'(0));

    // Two simultaneous writes: grants 0 then 1.
    req_we = 2'b11;
    req_addr = {3'd3, 3'd2};
    req_wdata = {16'hF080, 16'h8CFA};
    req_valid = 2'b11;
    wait_grant("dual_g0", g);
    chk("dual_g0", 32'(g), 32'(2'b01));
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("dual_w0_strobe", 32'(rf_write), 32'(1));
    chk("dual_w0_num", 32'(rf_writenum), 32'(2));
    chk("dual_ready_busy", 32'(req_ready), 32'(0));
    wait_grant("dual_g1", g);
    chk("dual_g1", 32'(g), 32'(2'b10));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("dual_w1_num", 32'(rf_writenum), 32'(3));
    chk("dual_w1_data", 32'(rf_data_in), 32'(16'hF080));
    @(posedge clk); #1;

    // Six reads with both held valid: grants alternate, response only to the owner.
    req_we = 2'b00;
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      int r;
      r = i % 2;
      wait_grant("alt_grant", g);
      chk("alt_grant", 32'(g), 32'(1 << r));
      @(posedge clk); #1;
      @(negedge clk);
      chk("alt_rsp_early", 32'(rsp_valid), 32'(0));
      @(negedge clk);
      chk("alt_rsp_valid", 32'(rsp_valid), 32'(1 << r));
      chk("alt_rsp_data", 32'(rsp_rdata), (r == 0) ? 32'(16'h8CFA) : 32'(16'hF080));
    end
    @(posedge clk); #1;
    req_valid = '0;

    // Single-requester vectors.
    for (int i = 0; i < 8; i++)
      run_op(tbl[i].tag, 0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp);

    // Reset during WRITE of addr 5: strobe falls at once and the old value survives.
    req_valid = 2'b01;
    req_we = 2'b01;
    req_addr[AW-1:0] = 3'd5;
    req_wdata[DW-1:0] = 16'hA800;
    wait_grant("rstw_grant", g);
    @(posedge clk); #1;
    req_valid = '0;
    chk("rstw_strobe_pre", 32'(rf_write), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("rstw_strobe_drop", 32'(rf_write), 32'(0));
    chk("rstw_num_clear", 32'(rf_writenum), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("rstw_read5", 0, 1'b0, 3'd5, 16'h0000, 16'h1234);

    // Reset during READ: the pending response never appears.
    req_valid = 2'b01;
    req_we = 2'b00;
    req_addr[AW-1:0] = 3'd1;
    wait_grant("rstr_grant", g);
    @(posedge clk); #1;
    req_valid = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstr_no_rsp", 32'(rsp_valid), 32'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
